// File: rtl/trng_pkg.sv
// Shared types and defaults for the ring-oscillator TRNG sequencer and its health test.
package trng_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CHAIN   = 3'd1,
        ST_WARMUP  = 3'd2,
        ST_COLLECT = 3'd3,
        ST_OUTPUT  = 3'd4,
        ST_FAULT   = 3'd5
    } trng_state_e;

    localparam int TRNG_WORD_W         = 32;
    localparam int TRNG_SAMPLE_DIV     = 4;
    localparam int TRNG_WARMUP_SAMPLES = 64;
    localparam int TRNG_REP_LIMIT      = 32;

    // Counter width able to hold 0..max_val inclusive.
    function automatic int cnt_w(input int max_val);
        return $clog2(max_val) + 1;
    endfunction

endpackage

// File: rtl/trng_health_rep.sv
// Repetition-count health test: pulses fault when REP_LIMIT identical raw samples arrive in a row.
module trng_health_rep
    import trng_pkg::*;
#(
    parameter int REP_LIMIT = TRNG_REP_LIMIT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic strobe,
    input  logic sample,
    output logic fault
);

    localparam int RW = cnt_w(REP_LIMIT);
    localparam logic [RW-1:0] LIMIT = RW'(REP_LIMIT);

    logic          last_q;
    logic [RW-1:0] run_q;
    logic [RW-1:0] run_d;

    // A zero run means no sample seen since the last clear.
    always_comb begin
        run_d = run_q;
        if (strobe) begin
            if (run_q == '0 || sample != last_q)
                run_d = RW'(1);
            else if (run_q != LIMIT)
                run_d = run_q + 1'b1;
        end
    end

    assign fault = strobe && (run_d == LIMIT);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            run_q  <= '0;
            last_q <= 1'b0;
        end else if (strobe) begin
            run_q  <= run_d;
            last_q <= sample;
        end
    end

endmodule

// File: rtl/trng_ctrl.sv
// Entropy-source sequencer: enable chain, warm-up, sampling, word packing, health test.
// Define TRNG_CTRL_VN_DEBIAS_EN to pack bits through a von Neumann debiaser.
module trng_ctrl
    import trng_pkg::*;
#(
    parameter int WORD_W         = TRNG_WORD_W,
    parameter int SAMPLE_DIV     = TRNG_SAMPLE_DIV,
    parameter int WARMUP_SAMPLES = TRNG_WARMUP_SAMPLES,
    parameter int REP_LIMIT      = TRNG_REP_LIMIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable_i,
    output logic              osc_en_o,
    input  logic              osc_chain_i,
    input  logic              osc_rnd_i,
    output logic [WORD_W-1:0] rnd_data_o,
    output logic              rnd_valid_o,
    input  logic              rnd_ready_i,
    output logic              fault_o,
    input  logic              clr_fault_i,
    output logic              busy_o
);

    localparam int DW = cnt_w(SAMPLE_DIV);
    localparam int WW = cnt_w(WARMUP_SAMPLES);
    localparam int BW = cnt_w(WORD_W);
    localparam logic [DW-1:0] DIV_LAST  = DW'(SAMPLE_DIV - 1);
    localparam logic [WW-1:0] WARM_LAST = WW'(WARMUP_SAMPLES - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(WORD_W - 1);

    trng_state_e       state_q, state_d;
    logic [DW-1:0]     div_q;
    logic [WW-1:0]     warm_q;
    logic [BW-1:0]     bit_q;
    logic [WORD_W-1:0] data_q;

    logic running, strobe, hfault, bit_ok, bit_val;
    logic warm_done, word_done, handshake;

    assign running = (state_q == ST_WARMUP) || (state_q == ST_COLLECT) || (state_q == ST_OUTPUT);
    assign strobe  = running && (div_q == DIV_LAST);

`ifdef TRNG_CTRL_VN_DEBIAS_EN
    logic pair_vld_q, pair_q;
    // Second sample of a pair emits the first one when they differ (01->0, 10->1).
    assign bit_ok  = strobe && (state_q == ST_COLLECT) && pair_vld_q && (pair_q != osc_rnd_i);
    assign bit_val = pair_q;

    always_ff @(posedge clk) begin
        if (rst || state_q != ST_COLLECT) begin
            pair_vld_q <= 1'b0;
            pair_q     <= 1'b0;
        end else if (strobe) begin
            pair_vld_q <= ~pair_vld_q;
            pair_q     <= osc_rnd_i;
        end
    end
`else
    assign bit_ok  = strobe && (state_q == ST_COLLECT);
    assign bit_val = osc_rnd_i;
`endif

    assign warm_done = strobe && (state_q == ST_WARMUP) && (warm_q == WARM_LAST);
    assign word_done = bit_ok && (bit_q == BIT_LAST);
    assign handshake = (state_q == ST_OUTPUT) && rnd_ready_i;

    trng_health_rep #(
        .REP_LIMIT(REP_LIMIT)
    ) u_health (
        .clk    (clk),
        .rst    (rst),
        .clr    (state_q == ST_IDLE),
        .strobe (strobe),
        .sample (osc_rnd_i),
        .fault  (hfault)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Priority inside the running states: health fault, then enable drop, then progress.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (enable_i) state_d = ST_CHAIN;
            ST_CHAIN: begin
                if (!enable_i)        state_d = ST_IDLE;
                else if (osc_chain_i) state_d = ST_WARMUP;
            end
            ST_WARMUP: begin
                if (hfault)         state_d = ST_FAULT;
                else if (!enable_i) state_d = ST_IDLE;
                else if (warm_done) state_d = ST_COLLECT;
            end
            ST_COLLECT: begin
                if (hfault)         state_d = ST_FAULT;
                else if (!enable_i) state_d = ST_IDLE;
                else if (word_done) state_d = ST_OUTPUT;
            end
            ST_OUTPUT: begin
                if (hfault)         state_d = ST_FAULT;
                else if (!enable_i) state_d = ST_IDLE;
                else if (handshake) state_d = ST_COLLECT;
            end
            ST_FAULT:   if (clr_fault_i) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        osc_en_o    = (state_q == ST_CHAIN) || running;
        busy_o      = (state_q == ST_CHAIN) || running;
        rnd_valid_o = (state_q == ST_OUTPUT);
        fault_o     = (state_q == ST_FAULT);
    end

    // Divider idles at zero outside the running states, so WARMUP always starts phase-aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q  <= '0;
            warm_q <= '0;
            bit_q  <= '0;
            data_q <= '0;
        end else begin
            div_q <= (running && !strobe) ? div_q + 1'b1 : '0;

            if (state_q != ST_WARMUP) warm_q <= '0;
            else if (strobe)          warm_q <= warm_q + 1'b1;

            if (state_q != ST_COLLECT) bit_q <= '0;
            else if (bit_ok)           bit_q <= bit_q + 1'b1;

            if (state_q == ST_IDLE || state_q == ST_FAULT) data_q <= '0;
            else if (bit_ok)                              data_q <= {data_q[WORD_W-2:0], bit_val};
        end
    end

    assign rnd_data_o = data_q;

endmodule

// File: doc/trng_ctrl.md
Name: trng_ctrl

Overview:
Sequencer for the ring-oscillator entropy source.
- Drives the oscillator enable chain and waits for the chain to report fully enabled.
- Discards a warm-up window of samples, then samples the synchronized random bit on a programmable strobe and packs bits into words.
- Runs a repetition-count health test on every raw sample.
- Presents words to a consumer on a valid/ready handshake; sits between the oscillator instance and the entropy consumer (e.g. a conditioner or CSR).

Parameters:
WORD_W, 32, output word width in bits (2..64)
SAMPLE_DIV, 4, clk cycles per sample strobe (>=1)
WARMUP_SAMPLES, 64, raw samples discarded after chain enable (>=1)
REP_LIMIT, 32, consecutive identical raw samples that trip the health fault (>=2)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
enable_i  input  1  level request to run the source
osc_en_o  output  1  enable-chain input to oscillator
osc_chain_i  input  1  enable-chain output from oscillator (all stages enabled)
osc_rnd_i  input  1  synchronized random bit from oscillator
rnd_data_o  output  WORD_W  assembled random word
rnd_valid_o  output  1  rnd_data_o valid
rnd_ready_i  input  1  consumer accepts word
fault_o  output  1  sticky health-test failure
clr_fault_i  input  1  clears fault_o, returns FSM to IDLE
busy_o  output  1  FSM not in IDLE/FAULT

Behaviour:
- One clock, synchronous active-high reset. Reset values: osc_en_o=0, rnd_data_o=0, rnd_valid_o=0, fault_o=0, busy_o=0, FSM=IDLE, all counters 0.
- FSM states: IDLE, CHAIN, WARMUP, COLLECT, OUTPUT, FAULT.
- IDLE: osc_en_o=0. enable_i=1 -> CHAIN.
- CHAIN: osc_en_o=1; waits for osc_chain_i=1, then -> WARMUP with divider and sample counters cleared.
- WARMUP: one sample per strobe; samples discarded, but fed to the health test. After WARMUP_SAMPLES strobes -> COLLECT.
- COLLECT: on each accepted bit, shift left and insert at LSB (first bit ends at MSB). After WORD_W accepted bits -> OUTPUT, with rnd_valid_o=1 the following cycle.
- OUTPUT: rnd_data_o and rnd_valid_o held stable until rnd_ready_i=1.
  - On handshake: rnd_valid_o=0 next cycle, bit counter cleared, -> COLLECT.
  - Oscillator keeps running; strobes during OUTPUT are health-tested but not packed (no buffering).
- Sample strobe: divider counts 0..SAMPLE_DIV-1 while in WARMUP/COLLECT/OUTPUT. Strobe when divider==SAMPLE_DIV-1, then wraps to 0. SAMPLE_DIV=1 means strobe every cycle.
- Health test:
  - Register the last raw sample plus a run counter.
  - Counter resets to 1 on a differing sample and increments on an equal one.
  - Counter==REP_LIMIT -> FAULT next cycle, regardless of current state (except IDLE).
  - Counter saturates and is cleared on entering CHAIN.
- FAULT: osc_en_o=0, rnd_valid_o=0, fault_o=1, pending word discarded. Only clr_fault_i (or rst) leaves: -> IDLE, fault_o=0.
- enable_i=0 in CHAIN/WARMUP/COLLECT/OUTPUT: -> IDLE next cycle, osc_en_o=0, rnd_valid_o=0, partial/pending word dropped. enable_i is ignored in FAULT.
- Simultaneous events, priority: rst > health fault > enable_i drop > handshake.
- Handshake in the same cycle as a fault: the word counts as not transferred.
- busy_o=1 in CHAIN, WARMUP, COLLECT, OUTPUT.
- Counter widths: $clog2 of the respective maximum + 1; no wrap-around beyond the terminal counts.

Optional Feature:
Macro TRNG_CTRL_VN_DEBIAS_EN.
- Defined: COLLECT packs bits through a von Neumann debiaser.
  - Raw samples are taken in pairs: 01->0, 10->1, 00/11 -> no bit.
  - The pair register clears on entering COLLECT.
  - Health test is still on raw samples.
- Not defined: every COLLECT strobe contributes its raw sample directly.

Decomposition:
- Package trng_pkg: FSM state enum (6 states, 3-bit encoding), default parameter constants, and a clog2-based width helper constant for the counters.
- Sub-module trng_health_rep: raw sample + strobe in, fault pulse out, clear input. It is reusable by other entropy sources.

Test Plan:
1. Reset, enable_i=1, osc_chain_i rises 5 cycles after osc_en_o, alternating osc_rnd_i per strobe -> WARMUP starts the cycle after osc_chain_i=1; first rnd_valid_o after 64+32 strobes (384 cycles at SAMPLE_DIV=4); word 0xAAAAAAAA or 0x55555555 per phase.
2. Hold rnd_ready_i=0 for 100 cycles while valid -> rnd_data_o stable, no new word. Pulse ready -> valid drops next cycle; next word after 32 further strobes.
3. osc_rnd_i stuck at 1 -> fault_o=1 on the cycle after the 32nd identical sample, osc_en_o=0, valid=0. enable_i toggling has no effect; clr_fault_i -> IDLE, fault_o=0.
4. Deassert enable_i mid-COLLECT after 10 bits -> IDLE next cycle, osc_en_o=0. Re-enable -> full CHAIN+WARMUP sequence repeats with no stale bits in the next word.
5. With TRNG_CTRL_VN_DEBIAS_EN, raw pair stream 01,10,00,11 repeated -> bits 0,1 only; a 32-bit word needs 64 raw pairs per 32 output bits; word = 0x55555555.
6. rst=1 asserted in OUTPUT simultaneously with rnd_ready_i=1 -> all outputs at reset values next cycle; no handshake counted.
